// File: rtl/ux607_tlwidthwidget_narrow_if.sv
// TileLink-UL A/D channel bundle. One instance per side of the width widget;
// DATA_BYTES sets the beat width of that side.
interface ux607_tlwidthwidget_narrow_if #(
   parameter int unsigned DATA_BYTES = 4,
   parameter int unsigned ADDR_W     = 30,
   parameter int unsigned SRC_W      = 2,
   parameter int unsigned SIZE_W     = 3
);
   logic                    a_valid;
   logic                    a_ready;
   logic [2:0]              a_opcode;
   logic [2:0]              a_param;
   logic [SIZE_W-1:0]       a_size;
   logic [SRC_W-1:0]        a_source;
   logic [ADDR_W-1:0]       a_address;
   logic [DATA_BYTES-1:0]   a_mask;
   logic [8*DATA_BYTES-1:0] a_data;

   logic                    d_valid;
   logic                    d_ready;
   logic [2:0]              d_opcode;
   logic [1:0]              d_param;
   logic [SIZE_W-1:0]       d_size;
   logic [SRC_W-1:0]        d_source;
   logic                    d_sink;
   logic                    d_error;
   logic [8*DATA_BYTES-1:0] d_data;

   modport master (
      output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
      input  a_ready,
      input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_error, d_data,
      output d_ready
   );

   modport slave (
      input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
      output a_ready,
      output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_error, d_data,
      input  d_ready
   );
endinterface

// File: rtl/ux607_tlwidthwidget_narrow.sv
// TileLink-UL width narrower: splits wide Put beats into narrow A beats and merges
// narrow AccessAckData beats back into one wide D beat.
module ux607_tlwidthwidget_narrow #(
   parameter int unsigned IN_BYTES  = 4,
   parameter int unsigned OUT_BYTES = 1,
   parameter int unsigned ADDR_W    = 30,
   parameter int unsigned SRC_W     = 2,
   parameter int unsigned SIZE_W    = 3
) (
   input  logic                                clock,
   input  logic                                reset,
   ux607_tlwidthwidget_narrow_if.slave         io_wide,
   ux607_tlwidthwidget_narrow_if.master        io_narrow
);
   localparam int unsigned R   = IN_BYTES / OUT_BYTES;
   localparam int unsigned DW  = 8 * OUT_BYTES;
   localparam int unsigned LSB = $clog2(OUT_BYTES);
   localparam int unsigned RW  = (R > 1) ? $clog2(R) : 1;

   assign io_narrow.a_valid  = io_wide.a_valid;
   assign io_narrow.a_opcode = io_wide.a_opcode;
   assign io_narrow.a_param  = io_wide.a_param;
   assign io_narrow.a_size   = io_wide.a_size;
   assign io_narrow.a_source = io_wide.a_source;
   assign io_wide.d_opcode   = io_narrow.d_opcode;
   assign io_wide.d_param    = io_narrow.d_param;
   assign io_wide.d_size     = io_narrow.d_size;
   assign io_wide.d_source   = io_narrow.d_source;
   assign io_wide.d_sink     = io_narrow.d_sink;

   // Narrow beats per wide beat for a given log2 transfer size.
   function automatic int unsigned beats_of(input logic [SIZE_W-1:0] sz);
      int unsigned nbytes;
      nbytes = 32'd1 << sz;
      if (nbytes <= OUT_BYTES) return 1;
      if (nbytes / OUT_BYTES >= R) return R;
      return nbytes / OUT_BYTES;
   endfunction

   generate
      if (R == 1) begin : g_wire
         assign io_narrow.a_address = io_wide.a_address;
         assign io_narrow.a_mask    = io_wide.a_mask;
         assign io_narrow.a_data    = io_wide.a_data;
         assign io_wide.a_ready     = io_narrow.a_ready;
         assign io_wide.d_valid     = io_narrow.d_valid;
         assign io_narrow.d_ready   = io_wide.d_ready;
         assign io_wide.d_error     = io_narrow.d_error;
         assign io_wide.d_data      = io_narrow.d_data;
      end else begin : g_narrow
         logic [RW-1:0]          r_a_cnt;
         logic [RW-1:0]          r_d_cnt;
         logic [R-2:0][DW-1:0]   r_acc;
         logic                   r_err_acc;
         int unsigned            w_a_k;
         int unsigned            w_d_k;
         logic                   w_a_put;
         logic                   w_a_last;
         logic                   w_d_merge;
         logic                   w_d_nonfinal;
         logic [RW-1:0]          w_lane;
         logic [RW-1:0]          w_slice;
         logic [RW-1:0]          w_d_kmask;
         logic [ADDR_W-1:0]      w_addr;
         logic [OUT_BYTES-1:0]   w_mask;
         logic [8*IN_BYTES-1:0]  w_d_data;

         assign w_a_k    = beats_of(io_wide.a_size);
         assign w_a_put  = (io_wide.a_opcode == 3'd0) || (io_wide.a_opcode == 3'd1);
         assign w_lane   = io_wide.a_address[LSB +: RW];
         assign w_slice  = w_a_put ? w_lane + r_a_cnt : w_lane;
         assign w_a_last = !w_a_put || (32'(r_a_cnt) == w_a_k - 32'd1);

         always_comb begin
            w_addr = io_wide.a_address;
            w_addr[LSB +: RW] = w_slice;
            w_mask = io_wide.a_mask[w_slice*OUT_BYTES +: OUT_BYTES];
            if (!w_a_put && ((32'd1 << io_wide.a_size) >= OUT_BYTES)) w_mask = '1;
         end

         assign io_narrow.a_address = w_addr;
         assign io_narrow.a_mask    = w_mask;
         assign io_narrow.a_data    = io_wide.a_data[w_slice*DW +: DW];
         assign io_wide.a_ready     = io_narrow.a_ready && w_a_last;

         assign w_d_k        = beats_of(io_narrow.d_size);
         assign w_d_merge    = (io_narrow.d_opcode == 3'd1) && (w_d_k > 1);
         assign w_d_nonfinal = w_d_merge && (32'(r_d_cnt) < w_d_k - 32'd1);
         assign w_d_kmask    = w_d_merge ? RW'(w_d_k - 32'd1) : '0;

         assign io_narrow.d_ready = w_d_nonfinal || io_wide.d_ready;
         assign io_wide.d_valid   = io_narrow.d_valid && !w_d_nonfinal;
         assign io_wide.d_error   = r_err_acc | io_narrow.d_error;
         assign io_wide.d_data    = w_d_data;

         // Slot s of the wide beat shows merged beat (s mod K); the live beat is always K-1.
         always_comb begin
            w_d_data = '0;
            for (int unsigned s = 0; s < R; s++) begin
               if ((RW'(s) & w_d_kmask) == w_d_kmask) w_d_data[s*DW +: DW] = io_narrow.d_data;
               else                                     w_d_data[s*DW +: DW] = r_acc[RW'(s) & w_d_kmask];
            end
         end

         always_ff @(posedge clock) begin
            if (reset) begin
               r_a_cnt   <= '0;
               r_d_cnt   <= '0;
               r_acc     <= '0;
               r_err_acc <= 1'b0;
            end else begin
               if (io_narrow.a_valid && io_narrow.a_ready && w_a_put)
                  r_a_cnt <= w_a_last ? '0 : r_a_cnt + 1'b1;
               if (io_narrow.d_valid && io_narrow.d_ready) begin
                  if (w_d_nonfinal) begin
                     r_acc[r_d_cnt] <= io_narrow.d_data;
                     r_err_acc      <= r_err_acc | io_narrow.d_error;
                     r_d_cnt        <= r_d_cnt + 1'b1;
                  end else if (w_d_merge) begin
                     r_d_cnt   <= '0;
                     r_err_acc <= 1'b0;
                  end
               end
            end
         end
      end
   endgenerate
endmodule

// File: tb/tb_ux607_tlwidthwidget_narrow.sv
// Self-checking bench for the 32->8 width narrower: scoreboarded A-beat splitting
// and D-beat merging, backpressure and mid-burst reset.
module tb_ux607_tlwidthwidget_narrow;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   typedef struct {
      logic [2:0]  op;
      logic [2:0]  sz;
      logic [29:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } a_txn_t;

   typedef struct {
      logic [29:0] addr;
      logic [7:0]  data;
      logic        mask;
      logic        rdy;
      logic [2:0]  sz;
   } a_exp_t;

   typedef struct {
      logic [2:0] op;
      logic [2:0] sz;
      logic [7:0] data;
      logic       err;
   } d_beat_t;

   typedef struct {
      logic [31:0] data;
      logic        err;
      logic [2:0]  op;
   } d_exp_t;

   a_exp_t a_q[$];
   d_exp_t d_q[$];

   ux607_tlwidthwidget_narrow_if #(.DATA_BYTES(4), .ADDR_W(30), .SRC_W(2), .SIZE_W(3)) w_wide ();
   ux607_tlwidthwidget_narrow_if #(.DATA_BYTES(1), .ADDR_W(30), .SRC_W(2), .SIZE_W(3)) w_narrow ();

   ux607_tlwidthwidget_narrow #(
      .IN_BYTES(4), .OUT_BYTES(1), .ADDR_W(30), .SRC_W(2), .SIZE_W(3)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .io_wide   (w_wide),
      .io_narrow (w_narrow)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

   task automatic drive_a(input a_txn_t t);
      w_wide.a_valid   = 1'b1;
      w_wide.a_opcode  = t.op;
      w_wide.a_param   = 3'd0;
      w_wide.a_size    = t.sz;
      w_wide.a_source  = 2'd1;
      w_wide.a_address = t.addr;
      w_wide.a_mask    = t.mask;
      w_wide.a_data    = t.data;
   endtask

   task automatic drive_d(input d_beat_t b);
      w_narrow.d_valid  = 1'b1;
      w_narrow.d_opcode = b.op;
      w_narrow.d_param  = 2'd0;
      w_narrow.d_size   = b.sz;
      w_narrow.d_source = 2'd2;
      w_narrow.d_sink   = 1'b0;
      w_narrow.d_error  = b.err;
      w_narrow.d_data   = b.data;
   endtask

   task automatic idle_all();
      w_wide.a_valid = 1'b0; w_wide.a_opcode = 3'd0; w_wide.a_param = 3'd0; w_wide.a_size = 3'd0;
      w_wide.a_source = 2'd0; w_wide.a_address = '0; w_wide.a_mask = '0; w_wide.a_data = '0;
      w_wide.d_ready = 1'b0;
      w_narrow.a_ready = 1'b0;
      w_narrow.d_valid = 1'b0; w_narrow.d_opcode = 3'd0; w_narrow.d_param = 2'd0;
      w_narrow.d_size = 3'd0; w_narrow.d_source = 2'd0; w_narrow.d_sink = 1'b0;
      w_narrow.d_error = 1'b0; w_narrow.d_data = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      w_narrow.a_ready = 1'b1;
      w_wide.d_ready   = 1'b1;
      @(negedge clock);
      n_cmp++;
      if ({w_wide.a_ready, w_narrow.a_valid, w_wide.d_valid, w_narrow.d_ready} !== 4'b1001) begin
         n_err++;
         $display("FAIL reset_idle_hi: got a_rdy/a_vld/d_vld/d_rdy=%b, want 1001",
                  {w_wide.a_ready, w_narrow.a_valid, w_wide.d_valid, w_narrow.d_ready});
      end
      @(posedge clock); #1;
      w_narrow.a_ready = 1'b0;
      w_wide.d_ready   = 1'b0;
      @(negedge clock);
      n_cmp++;
      if ({w_wide.a_ready, w_narrow.a_valid, w_wide.d_valid, w_narrow.d_ready} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_idle_lo: got a_rdy/a_vld/d_vld/d_rdy=%b, want 0000",
                  {w_wide.a_ready, w_narrow.a_valid, w_wide.d_valid, w_narrow.d_ready});
      end
      @(posedge clock); #1;
   endtask

   // Back-to-back Puts: full, byte partial, half-word, and a lane-wrapping full word.
   task automatic test_put_split();
      a_txn_t     t[4];
      a_exp_t     e;
      int         i;
      int         k;
      logic [1:0] sl;
      logic       adv;
      t[0] = '{3'd0, 3'd2, 30'h100, 32'hDDCCBBAA, 4'hF};
      t[1] = '{3'd1, 3'd0, 30'h102, 32'h00EE0000, 4'h4};
      t[2] = '{3'd1, 3'd1, 30'h102, 32'h12340000, 4'hC};
      t[3] = '{3'd0, 3'd2, 30'h102, 32'h87654321, 4'hF};
      for (int n = 0; n < 4; n++) begin
         k = (t[n].sz == 3'd0) ? 1 : (((1 << t[n].sz) > 4) ? 4 : (1 << t[n].sz));
         for (int j = 0; j < k; j++) begin
            sl     = t[n].addr[1:0] + 2'(j);
            e.addr = {t[n].addr[29:2], sl};
            e.data = 8'(t[n].data >> (8 * sl));
            e.mask = t[n].mask[sl];
            e.rdy  = (j == k - 1);
            e.sz   = t[n].sz;
            a_q.push_back(e);
         end
      end
      i = 0;
      drive_a(t[0]);
      w_narrow.a_ready = 1'b1;
      for (int c = 0; c < 40 && i < 4; c++) begin
         @(negedge clock);
         adv = 1'b0;
         if (w_narrow.a_valid && w_narrow.a_ready) begin
            n_cmp++;
            if (a_q.size() == 0) begin
               n_err++;
               $display("FAIL put_split extra: got beat addr=%h, want none", w_narrow.a_address);
            end else begin
               e = a_q.pop_front();
               if ({w_narrow.a_address, w_narrow.a_data, w_narrow.a_mask, w_wide.a_ready,
                    w_narrow.a_size, w_narrow.a_source} !==
                   {e.addr, e.data, e.mask, e.rdy, e.sz, 2'd1}) begin
                  n_err++;
                  $display("FAIL put_split beat: got addr=%h data=%h mask=%b rdy=%b sz=%0d src=%0d, want addr=%h data=%h mask=%b rdy=%b sz=%0d src=1",
                           w_narrow.a_address, w_narrow.a_data, w_narrow.a_mask, w_wide.a_ready,
                           w_narrow.a_size, w_narrow.a_source, e.addr, e.data, e.mask, e.rdy, e.sz);
               end
            end
            adv = w_wide.a_ready;
         end
         @(posedge clock); #1;
         if (adv) begin
            i++;
            if (i < 4) drive_a(t[i]);
            else w_wide.a_valid = 1'b0;
         end
      end
      w_wide.a_valid = 1'b0;
      n_cmp++;
      if (a_q.size() != 0) begin
         n_err++;
         $display("FAIL put_split drain: got %0d beats pending, want 0", a_q.size());
      end
      a_q.delete();
   endtask

   // Get is single-beat and must not advance the Put beat counter.
   task automatic test_get();
      drive_a('{3'd4, 3'd2, 30'h200, 32'h11223344, 4'hF});
      w_narrow.a_ready = 1'b1;
      @(negedge clock);
      n_cmp++;
      if ({w_narrow.a_valid, w_narrow.a_address, w_narrow.a_data, w_narrow.a_mask, w_wide.a_ready} !==
          {1'b1, 30'h200, 8'h44, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL get_beat: got vld=%b addr=%h data=%h mask=%b rdy=%b, want vld=1 addr=200 data=44 mask=1 rdy=1",
                  w_narrow.a_valid, w_narrow.a_address, w_narrow.a_data, w_narrow.a_mask, w_wide.a_ready);
      end
      @(posedge clock); #1;
      drive_a('{3'd0, 3'd1, 30'h200, 32'h0000BBAA, 4'h3});
      @(negedge clock);
      n_cmp++;
      if ({w_narrow.a_address, w_narrow.a_data, w_wide.a_ready} !== {30'h200, 8'hAA, 1'b0}) begin
         n_err++;
         $display("FAIL get_cnt_untouched: got addr=%h data=%h rdy=%b, want addr=200 data=aa rdy=0",
                  w_narrow.a_address, w_narrow.a_data, w_wide.a_ready);
      end
      @(posedge clock); #1;
      @(posedge clock); #1;
      w_wide.a_valid = 1'b0;
   endtask

   task automatic test_d_merge();
      d_beat_t b[10];
      d_exp_t  e;
      int      i;
      logic    adv;
      b[0] = '{3'd1, 3'd2, 8'h11, 1'b0}; b[1] = '{3'd1, 3'd2, 8'h22, 1'b0};
      b[2] = '{3'd1, 3'd2, 8'h33, 1'b0}; b[3] = '{3'd1, 3'd2, 8'h44, 1'b0};
      b[4] = '{3'd1, 3'd1, 8'h5A, 1'b1}; b[5] = '{3'd1, 3'd1, 8'hA5, 1'b0};
      b[6] = '{3'd1, 3'd1, 8'h01, 1'b0}; b[7] = '{3'd1, 3'd1, 8'h02, 1'b0};
      b[8] = '{3'd0, 3'd2, 8'h00, 1'b0}; b[9] = '{3'd1, 3'd0, 8'h7E, 1'b1};
      d_q.push_back('{32'h44332211, 1'b0, 3'd1});
      d_q.push_back('{32'hA55AA55A, 1'b1, 3'd1});
      d_q.push_back('{32'h02010201, 1'b0, 3'd1});
      d_q.push_back('{32'h00000000, 1'b0, 3'd0});
      d_q.push_back('{32'h7E7E7E7E, 1'b1, 3'd1});
      i = 0;
      drive_d(b[0]);
      w_wide.d_ready = 1'b1;
      for (int c = 0; c < 40 && i < 10; c++) begin
         @(negedge clock);
         n_cmp++;
         if (w_narrow.d_ready !== 1'b1) begin
            n_err++;
            $display("FAIL d_merge out_d_ready beat %0d: got %b, want 1", i, w_narrow.d_ready);
         end
         if (w_wide.d_valid && w_wide.d_ready) begin
            n_cmp++;
            if (d_q.size() == 0) begin
               n_err++;
               $display("FAIL d_merge extra: got in_d data=%h, want none", w_wide.d_data);
            end else begin
               e = d_q.pop_front();
               if ({w_wide.d_data, w_wide.d_error, w_wide.d_opcode, w_wide.d_source} !==
                   {e.data, e.err, e.op, 2'd2}) begin
                  n_err++;
                  $display("FAIL d_merge beat: got data=%h err=%b op=%0d src=%0d, want data=%h err=%b op=%0d src=2",
                           w_wide.d_data, w_wide.d_error, w_wide.d_opcode, w_wide.d_source,
                           e.data, e.err, e.op);
               end
            end
         end
         adv = w_narrow.d_valid && w_narrow.d_ready;
         @(posedge clock); #1;
         if (adv) begin
            i++;
            if (i < 10) drive_d(b[i]);
            else w_narrow.d_valid = 1'b0;
         end
      end
      w_narrow.d_valid = 1'b0;
      n_cmp++;
      if (d_q.size() != 0) begin
         n_err++;
         $display("FAIL d_merge drain: got %0d responses pending, want 0", d_q.size());
      end
      d_q.delete();
   endtask

   task automatic test_backpressure();
      d_exp_t e;
      int     i;
      logic   adv;
      logic   exp_rdy;
      logic   exp_vld;
      d_q.push_back('{32'h44332211, 1'b0, 3'd1});
      i = 0;
      drive_d('{3'd1, 3'd2, 8'h11, 1'b0});
      w_wide.d_ready = 1'b0;
      for (int c = 0; c < 7; c++) begin
         if (c == 6) w_wide.d_ready = 1'b1;
         @(negedge clock);
         exp_rdy = (c < 3) || (c == 6);
         exp_vld = (c >= 3);
         n_cmp++;
         if ({w_narrow.d_ready, w_wide.d_valid} !== {exp_rdy, exp_vld}) begin
            n_err++;
            $display("FAIL backpressure hs cycle %0d: got out_d_ready=%b in_d_valid=%b, want %b %b",
                     c, w_narrow.d_ready, w_wide.d_valid, exp_rdy, exp_vld);
         end
         if (c >= 3 && c < 6) begin
            n_cmp++;
            if (w_wide.d_data !== 32'h44332211) begin
               n_err++;
               $display("FAIL backpressure hold cycle %0d: got data=%h, want 44332211", c, w_wide.d_data);
            end
         end
         if (w_wide.d_valid && w_wide.d_ready && d_q.size() != 0) begin
            e = d_q.pop_front();
            n_cmp++;
            if ({w_wide.d_data, w_wide.d_error} !== {e.data, e.err}) begin
               n_err++;
               $display("FAIL backpressure deliver: got data=%h err=%b, want data=%h err=%b",
                        w_wide.d_data, w_wide.d_error, e.data, e.err);
            end
         end
         adv = w_narrow.d_valid && w_narrow.d_ready;
         @(posedge clock); #1;
         if (adv) begin
            i++;
            if (i < 4) drive_d('{3'd1, 3'd2, 8'(8'h11 * (i + 1)), 1'b0});
            else w_narrow.d_valid = 1'b0;
         end
      end
      w_narrow.d_valid = 1'b0;
      n_cmp++;
      if (d_q.size() != 0) begin
         n_err++;
         $display("FAIL backpressure drain: got %0d responses pending, want 0", d_q.size());
      end
      d_q.delete();
   endtask

   // A and D both run two beats concurrently, then reset drops both partial bursts.
   task automatic test_reset_mid();
      a_exp_t ea;
      d_exp_t ed;
      int     di;
      logic   a_done;
      logic   adv_d;
      drive_a('{3'd0, 3'd2, 30'h100, 32'hDDCCBBAA, 4'hF});
      drive_d('{3'd1, 3'd2, 8'h99, 1'b1});
      w_narrow.a_ready = 1'b1;
      w_wide.d_ready   = 1'b1;
      @(posedge clock); #1;
      drive_d('{3'd1, 3'd2, 8'h88, 1'b0});
      @(posedge clock); #1;
      w_wide.a_valid   = 1'b0;
      w_narrow.d_valid = 1'b0;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      for (int j = 0; j < 4; j++) a_q.push_back('{30'h104 + 30'(j), 8'(8'h11 * (j + 1)), 1'b1, j == 3, 3'd2});
      d_q.push_back('{32'h02010201, 1'b0, 3'd1});
      drive_a('{3'd0, 3'd2, 30'h104, 32'h44332211, 4'hF});
      drive_d('{3'd1, 3'd1, 8'h01, 1'b0});
      di = 0;
      for (int c = 0; c < 10 && (a_q.size() != 0 || d_q.size() != 0); c++) begin
         @(negedge clock);
         a_done = 1'b0;
         if (w_narrow.a_valid && w_narrow.a_ready && a_q.size() != 0) begin
            ea = a_q.pop_front();
            n_cmp++;
            if ({w_narrow.a_address, w_narrow.a_data, w_wide.a_ready} !== {ea.addr, ea.data, ea.rdy}) begin
               n_err++;
               $display("FAIL reset_mid A: got addr=%h data=%h rdy=%b, want addr=%h data=%h rdy=%b",
                        w_narrow.a_address, w_narrow.a_data, w_wide.a_ready, ea.addr, ea.data, ea.rdy);
            end
            a_done = w_wide.a_ready;
         end
         if (w_wide.d_valid && w_wide.d_ready && d_q.size() != 0) begin
            ed = d_q.pop_front();
            n_cmp++;
            if ({w_wide.d_data, w_wide.d_error} !== {ed.data, ed.err}) begin
               n_err++;
               $display("FAIL reset_mid D: got data=%h err=%b, want data=%h err=%b",
                        w_wide.d_data, w_wide.d_error, ed.data, ed.err);
            end
         end
         adv_d = w_narrow.d_valid && w_narrow.d_ready;
         @(posedge clock); #1;
         if (a_done) w_wide.a_valid = 1'b0;
         if (adv_d) begin
            di++;
            if (di == 1) drive_d('{3'd1, 3'd1, 8'h02, 1'b0});
            else w_narrow.d_valid = 1'b0;
         end
      end
      w_wide.a_valid   = 1'b0;
      w_narrow.d_valid = 1'b0;
      n_cmp++;
      if (a_q.size() != 0 || d_q.size() != 0) begin
         n_err++;
         $display("FAIL reset_mid drain: got %0d A / %0d D pending, want 0 / 0", a_q.size(), d_q.size());
      end
      a_q.delete();
      d_q.delete();
   endtask

   initial begin
      idle_all();
      test_reset();
      test_put_split();
      test_get();
      test_d_merge();
      test_backpressure();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
